// File: rtl/branch_pc_unit.sv
// branch_pc_unit
//
// Program counter and control-transfer unit for a MIPS-style core with a
// single architectural branch delay slot.
//
// The unit decodes control transfers directly from the instruction that
// instr_address is currently fetching. It uses the ALU flags in that same
// cycle. A taken transfer does not redirect the PC at once. It latches the
// destination, lets the next sequential instruction run as the delay slot,
// and then jumps. A transfer whose destination is 0x00000000 halts the core.
//
// Ports
//   clk            in   1   single clock, rising edge
//   reset          in   1   synchronous, active-high; overrides stall and state
//   stall          in   1   freeze all state for the cycle
//   instr_readdata in  32   instruction at instr_address
//   rs_data        in  32   register rs value (JR/JALR destination)
//   EQ, N, Z       in   1   ALU flags: rs==rt, rs<0 (signed), rs==0
//   instr_address  out 32   PC of the instruction in execution
//   B_link         out  1   link write request (JAL/JALR/BLTZAL/BGEZAL in RUN)
//   active         out  1   low once halted
//   delay_slot     out  1   current instruction is a branch delay slot

module branch_pc_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] instr_readdata,
    input  logic [31:0] rs_data,
    input  logic        EQ,
    input  logic        N,
    input  logic        Z,
    output logic [31:0] instr_address,
    output logic        B_link,
    output logic        active,
    output logic        delay_slot
);

    localparam logic [31:0] ResetPc = 32'hBFC0_0000;

    // Opcodes and function codes of the recognised control transfers.
    localparam logic [5:0] OpSpecial = 6'd0;
    localparam logic [5:0] OpRegimm  = 6'd1;
    localparam logic [5:0] OpJ       = 6'd2;
    localparam logic [5:0] OpJal     = 6'd3;
    localparam logic [5:0] OpBeq     = 6'd4;
    localparam logic [5:0] OpBne     = 6'd5;
    localparam logic [5:0] OpBlez    = 6'd6;
    localparam logic [5:0] OpBgtz    = 6'd7;
    localparam logic [5:0] FnJr      = 6'd8;
    localparam logic [5:0] FnJalr    = 6'd9;
    localparam logic [4:0] RtBltz    = 5'd0;
    localparam logic [4:0] RtBgez    = 5'd1;
    localparam logic [4:0] RtBltzal  = 5'd16;
    localparam logic [4:0] RtBgezal  = 5'd17;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StDelay  = 2'd1,
        StHalted = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target_q, target_d;

    // Instruction fields
    logic [5:0]  opcode;
    logic [4:0]  rt_field;
    logic [5:0]  funct;
    logic [15:0] imm;

    assign opcode   = instr_readdata[31:26];
    assign rt_field = instr_readdata[20:16];
    assign funct    = instr_readdata[5:0];
    assign imm      = instr_readdata[15:0];

    // Candidate destinations
    logic [31:0] pc_plus4;
    logic [31:0] branch_offset;
    logic [31:0] branch_target;
    logic [31:0] jump_target;

    assign pc_plus4      = pc_q + 32'd4;
    assign branch_offset = {{14{imm[15]}}, imm, 2'b00};
    assign branch_target = pc_plus4 + branch_offset;
    assign jump_target   = {pc_plus4[31:28], instr_readdata[25:0], 2'b00};

    // Decode: whether the fetched instruction transfers control, where to,
    // and whether it requests a link write. The link request does not
    // depend on the branch outcome.
    logic        xfer_taken;
    logic [31:0] xfer_target;
    logic        is_link;

    always_comb begin
        xfer_taken  = 1'b0;
        xfer_target = branch_target;
        is_link     = 1'b0;

        unique case (opcode)
            OpSpecial: begin
                if (funct == FnJr) begin
                    xfer_taken  = 1'b1;
                    xfer_target = rs_data;
                end else if (funct == FnJalr) begin
                    xfer_taken  = 1'b1;
                    xfer_target = rs_data;
                    is_link     = 1'b1;
                end
            end
            OpRegimm: begin
                if (rt_field == RtBltz) begin
                    xfer_taken = N;
                end else if (rt_field == RtBgez) begin
                    xfer_taken = ~N;
                end else if (rt_field == RtBltzal) begin
                    xfer_taken = N;
                    is_link    = 1'b1;
                end else if (rt_field == RtBgezal) begin
                    xfer_taken = ~N;
                    is_link    = 1'b1;
                end
            end
            OpJ: begin
                xfer_taken  = 1'b1;
                xfer_target = jump_target;
            end
            OpJal: begin
                xfer_taken  = 1'b1;
                xfer_target = jump_target;
                is_link     = 1'b1;
            end
            OpBeq:  xfer_taken = EQ;
            OpBne:  xfer_taken = ~EQ;
            OpBlez: xfer_taken = N | Z;
            OpBgtz: xfer_taken = ~N & ~Z;
            default: ;
        endcase
    end

    // Next-state logic. Stall freezes everything. Decode is used only in
    // RUN, so a transfer sitting in the delay slot has no effect on control flow.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;

        if (!stall) begin
            unique case (state_q)
                StRun: begin
                    pc_d = pc_plus4;
                    if (xfer_taken) begin
                        target_d = xfer_target;
                        state_d  = StDelay;
                    end
                end
                StDelay: begin
                    pc_d    = target_q;
                    state_d = (target_q == 32'h0000_0000) ? StHalted : StRun;
                end
                StHalted: begin
                    pc_d = 32'h0000_0000;
                end
                default: begin
                    state_d = StHalted;
                    pc_d    = 32'h0000_0000;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StRun;
            pc_q     <= ResetPc;
            target_q <= 32'h0000_0000;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
        end
    end

    assign instr_address = pc_q;
    assign delay_slot    = (state_q == StDelay);
    assign active        = (state_q != StHalted);
    assign B_link        = (state_q == StRun) & is_link;

endmodule

// File: tb/tb_branch_pc_unit.sv
module tb_branch_pc_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] instr_readdata;
    logic [31:0] rs_data;
    logic        EQ;
    logic        N;
    logic        Z;
    logic [31:0] instr_address;
    logic        B_link;
    logic        active;
    logic        delay_slot;

    int checks;
    int failures;

    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] BEQ_P3   = 32'h1022_0003; // beq imm=+3
    localparam logic [31:0] BGEZAL   = 32'h0471_0010; // bgezal rs=3 imm=0x10
    localparam logic [31:0] BNE_P4   = 32'h1422_0004; // bne imm=+4
    localparam logic [31:0] JAL_X    = 32'h0C00_0100; // jal 0x100
    localparam logic [31:0] J_100    = 32'h0BF0_0040; // j -> 0xBFC00100 from 0xBxxxxxxx
    localparam logic [31:0] JR_R4    = 32'h0080_0008; // jr r4

    branch_pc_unit dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .instr_readdata (instr_readdata),
        .rs_data        (rs_data),
        .EQ             (EQ),
        .N              (N),
        .Z              (Z),
        .instr_address  (instr_address),
        .B_link         (B_link),
        .active         (active),
        .delay_slot     (delay_slot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pc, input logic ds,
                             input logic act);
        chk({tag, "_pc"}, instr_address, pc);
        chk({tag, "_ds"}, {31'd0, delay_slot}, {31'd0, ds});
        chk({tag, "_act"}, {31'd0, active}, {31'd0, act});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b0;
        stall          = 1'b0;
        instr_readdata = NOP;
        rs_data        = 32'h0;
        EQ             = 1'b0;
        N              = 1'b0;
        Z              = 1'b0;

        // Reset, then three sequential instructions
        do_reset();
        chk_state("rst", 32'hBFC0_0000, 1'b0, 1'b1);
        step(); chk("seq1", instr_address, 32'hBFC0_0004);
        step(); chk("seq2", instr_address, 32'hBFC0_0008);
        step(); chk("seq3", instr_address, 32'hBFC0_000C);
        step(); chk("seq4", instr_address, 32'hBFC0_0010);

        // BEQ taken at 0xBFC00010 -> delay slot 0x14 -> 0x20
        instr_readdata = BEQ_P3; EQ = 1'b1;
        #1 chk("beq_link", {31'd0, B_link}, 32'd0);
        step(); chk_state("beq_t_ds", 32'hBFC0_0014, 1'b1, 1'b1);
        instr_readdata = NOP; EQ = 1'b0;
        step(); chk_state("beq_t_tgt", 32'hBFC0_0020, 1'b0, 1'b1);

        // BEQ not taken at 0xBFC00010 -> 0x14 -> 0x18
        do_reset();
        repeat (4) step();
        chk("beq_nt_pc0", instr_address, 32'hBFC0_0010);
        instr_readdata = BEQ_P3; EQ = 1'b0;
        step(); chk_state("beq_nt_1", 32'hBFC0_0014, 1'b0, 1'b1);
        instr_readdata = NOP;
        step(); chk_state("beq_nt_2", 32'hBFC0_0018, 1'b0, 1'b1);

        // BGEZAL with N=1: link requested, not taken
        do_reset();
        instr_readdata = BGEZAL; N = 1'b1;
        #1 chk("bgezal_link", {31'd0, B_link}, 32'd1);
        step(); chk_state("bgezal_nt", 32'hBFC0_0004, 1'b0, 1'b1);
        N = 1'b0;

        // Taken BNE at 0x04, JAL in the delay slot is ignored -> 0x18
        instr_readdata = BNE_P4; EQ = 1'b0;
        step(); chk_state("bne_ds", 32'hBFC0_0008, 1'b1, 1'b1);
        instr_readdata = JAL_X;
        #1 chk("ds_link_low", {31'd0, B_link}, 32'd0);
        step(); chk_state("bne_tgt", 32'hBFC0_0018, 1'b0, 1'b1);
        instr_readdata = NOP;
        step(); chk("after_bne", instr_address, 32'hBFC0_001C);

        // J at 0x1C, stall two cycles in DELAY, then reset in DELAY
        instr_readdata = J_100;
        step(); chk_state("j_ds", 32'hBFC0_0020, 1'b1, 1'b1);
        stall = 1'b1; instr_readdata = BNE_P4;
        step(); chk_state("stall1", 32'hBFC0_0020, 1'b1, 1'b1);
        step(); chk_state("stall2", 32'hBFC0_0020, 1'b1, 1'b1);
        reset = 1'b1;
        step(); chk_state("rst_in_ds", 32'hBFC0_0000, 1'b0, 1'b1);
        reset = 1'b0; stall = 1'b0; instr_readdata = NOP;
        step(); chk_state("tgt_dropped", 32'hBFC0_0004, 1'b0, 1'b1);

        // Stall in RUN on a jump: no state change, then normal transfer
        instr_readdata = J_100; stall = 1'b1;
        step(); chk_state("stall_run", 32'hBFC0_0004, 1'b0, 1'b1);
        stall = 1'b0;
        step(); chk_state("j2_ds", 32'hBFC0_0008, 1'b1, 1'b1);
        instr_readdata = NOP;
        step(); chk_state("j2_tgt", 32'hBFC0_0100, 1'b0, 1'b1);

        // JR to 0 -> delay slot -> halted and held
        instr_readdata = JR_R4; rs_data = 32'h0;
        step(); chk_state("jr_ds", 32'hBFC0_0104, 1'b1, 1'b1);
        instr_readdata = NOP;
        step(); chk_state("halt", 32'h0000_0000, 1'b0, 1'b0);
        instr_readdata = JR_R4; rs_data = 32'h1234_5678;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_state("halt_hold", 32'h0000_0000, 1'b0, 1'b0);
            chk("halt_link", {31'd0, B_link}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_pc_unit.md
BRANCH_PC_UNIT -- requirements
Module: branch_pc_unit

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port stall  input  1  when high, all internal state and outputs hold for that cycle.
REQ-004 SHALL have port instr_readdata  input  32  instruction currently addressed by instr_address.
REQ-005 SHALL have port rs_data  input  32  register rs value from datapath read_data_0.
REQ-006 SHALL have port EQ  input  1  ALU flag: rs == rt.
REQ-007 SHALL have port N  input  1  ALU flag: rs < 0, signed.
REQ-008 SHALL have port Z  input  1  ALU flag: rs == 0.
REQ-009 SHALL have port instr_address  output  32  PC of the instruction in execution; feeds datapath link computation (PC+8).
REQ-010 SHALL have port B_link  output  1  link write request to datapath.
REQ-011 SHALL have port active  output  1  high while CPU runs, low once halted.
REQ-012 SHALL have port delay_slot  output  1  high while the current instruction is a branch delay slot.

Function
REQ-013 SHALL implement states RUN, DELAY, HALTED; delay_slot = (state == DELAY); active = (state != HALTED).
REQ-014 SHALL decode transfers from instr_readdata: opcode 4 BEQ (EQ), 5 BNE (!EQ), 6 BLEZ (N|Z), 7 BGTZ (!N&!Z), 2 J, 3 JAL, opcode 0 funct 8 JR, funct 9 JALR.
REQ-015 SHALL decode opcode 1 by rt: 0 BLTZ (N), 1 BGEZ (!N), 16 BLTZAL (N), 17 BGEZAL (!N); other rt values are not transfers.
REQ-016 SHALL compute branch target = instr_address + 4 + (sign-extended imm[15:0] << 2), modulo 2^32.
REQ-017 SHALL compute J/JAL target = {(instr_address+4)[31:28], instr_readdata[25:0], 2'b00}; JR/JALR target = rs_data unmodified.
REQ-018 SHALL, in RUN with stall low and a taken transfer (J/JAL/JR/JALR always taken), latch target into a target register, set PC to PC+4, and enter DELAY.
REQ-019 SHALL, in RUN with no taken transfer and stall low, set PC to PC+4 and remain in RUN.
REQ-020 SHALL, in DELAY with stall low, set PC to latched target; enter HALTED if target == 0x00000000, else RUN.
REQ-021 SHALL NOT decode transfers while in DELAY; a branch in the delay slot executes as a no-op for control flow.
REQ-022 SHALL assert B_link combinationally in RUN for JAL, JALR, BLTZAL, BGEZAL, whether or not the branch is taken; low in DELAY and HALTED.
REQ-023 SHALL, in HALTED, hold instr_address at 0x00000000 and ignore instr_readdata until reset.
REQ-024 SHALL give stall priority over every transition except reset; the target register is not overwritten under stall.
REQ-025 SHALL evaluate flags in the same cycle as the branch instruction is on instr_readdata; zero extra latency.

Reset
REQ-026 SHALL, on reset high at a clock edge, set instr_address=0xBFC00000, state=RUN, target register=0, delay_slot=0, active=1.
REQ-027 SHALL let reset override stall and any state, including DELAY mid-transfer; the pending target is discarded.
REQ-028 SHALL drive B_link from decode only; B_link may be high in the reset cycle and carries no meaning until reset is released.

Verification
REQ-029 SHALL cover: reset, then 3 non-branch instructions -> instr_address 0xBFC00000, 0xBFC00004, 0xBFC00008, 0xBFC0000C.
REQ-030 SHALL cover: BEQ imm=0x0003, EQ=1, at PC 0xBFC00010 -> next PC 0xBFC00014 with delay_slot=1, then 0xBFC00020; repeated with EQ=0 -> 0xBFC00018.
REQ-031 SHALL cover: BGEZAL at PC 0xBFC00000 with N=1 -> B_link=1, not taken, PC 0xBFC00004, delay_slot=0.
REQ-032 SHALL cover: JR with rs_data=0 -> delay slot at PC+4, then instr_address=0, active=0, held for 10 cycles.
REQ-033 SHALL cover: J in the DELAY slot of a taken BNE -> J ignored, PC goes to BNE target.
REQ-034 SHALL cover: stall high for 2 cycles in DELAY, then reset asserted in DELAY -> PC held during stall; after reset, PC 0xBFC00000, delay_slot=0.
